// File: rtl/act_unit_rdiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | act_unit_rdiv : handshaked sigmoid/tanh via x/(1+|x|), restoring divider    |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module act_unit_rdiv #(
  parameter int IBIT = 32,
  parameter int FBIT = 10,
  parameter int OBIT = 12,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IBIT-1:0] in_data,
  input  logic            in_mode,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OBIT-1:0] out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  localparam int CW = $clog2(FBIT + 1);

  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_prep = 3'd1;
  localparam logic [2:0] c_div  = 3'd2;
  localparam logic [2:0] c_fin  = 3'd3;
  localparam logic [2:0] c_done = 3'd4;

  localparam logic [IBIT-1:0] c_min    = {1'b1, {(IBIT-1){1'b0}}};
  localparam logic [IBIT-1:0] c_max    = {1'b0, {(IBIT-1){1'b1}}};
  localparam logic [IBIT:0]   c_unit   = {{(IBIT-FBIT){1'b0}}, 1'b1, {FBIT{1'b0}}};
  localparam logic [OBIT-1:0] c_one    = {{(OBIT-FBIT-1){1'b0}}, 1'b1, {FBIT{1'b0}}};
  localparam logic [CW-1:0]   c_last   = CW'(FBIT - 1);

  logic [2:0]             r_state;
  logic [2:0]             w_next;
  logic [IBIT-1:0]        r_x;
  logic                   r_mode;
  logic [TAGW-1:0]        r_tag;
  logic [IBIT:0]          r_rem;
  logic [IBIT:0]          r_div;
  logic [FBIT-1:0]        r_q;
  logic [CW-1:0]          r_cnt;

  logic [IBIT-1:0]        w_abs;
  logic [IBIT:0]          w_r2;
  logic [IBIT:0]          w_sub;
  logic                   w_ge;
  logic signed [OBIT-1:0] w_qx;
  logic signed [OBIT-1:0] w_t;
  logic signed [OBIT-1:0] w_sum;
  logic signed [OBIT-1:0] w_sig;

  // Most negative input has no positive twin; clamp it to the largest magnitude.
  assign w_abs = !r_x[IBIT-1] ? r_x : ((r_x == c_min) ? c_max : -r_x);

  // r < d always holds, so the top bit of r is zero and the shift cannot lose data.
  assign w_r2  = r_rem << 1;
  assign w_ge  = (w_r2 >= r_div);
  assign w_sub = w_r2 - r_div;

  assign w_qx  = {{(OBIT-FBIT){1'b0}}, r_q};
  assign w_t   = r_x[IBIT-1] ? -w_qx : w_qx;
  assign w_sum = c_one + w_t;
  assign w_sig = w_sum >>> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (in_valid) w_next = c_prep;
      c_prep:  w_next = c_div;
      c_div:   if (r_cnt == c_last) w_next = c_fin;
      c_fin:   w_next = c_done;
      c_done:  if (out_ready) w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  always_comb begin
    in_ready = (r_state == c_idle);
    busy     = (r_state != c_idle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x       <= '0;
      r_mode    <= 1'b0;
      r_tag     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_x    <= in_data;
            r_mode <= in_mode;
            r_tag  <= in_tag;
          end
        end
        c_prep: begin
          r_rem <= {1'b0, w_abs};
          r_div <= {1'b0, w_abs} + c_unit;
          r_q   <= '0;
          r_cnt <= '0;
        end
        c_div: begin
          r_rem <= w_ge ? w_sub : w_r2;
          r_q   <= {r_q[FBIT-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        c_fin: begin
          out_data  <= r_mode ? w_t : w_sig;
          out_tag   <= r_tag;
          out_valid <= 1'b1;
        end
        c_done: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_act_unit_rdiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_act_unit_rdiv : directed and randomised checks for act_unit_rdiv         |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_act_unit_rdiv;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               in_mode;
  logic [3:0]         in_tag;
  logic               out_valid;
  logic               out_ready;
  logic signed [11:0] out_data;
  logic [3:0]         out_tag;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  act_unit_rdiv #(.IBIT(32), .FBIT(10), .OBIT(12), .TAGW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Closed-form reference: q = floor(a*1024/(a+1024)), independent of the bit loop.
  function automatic int ref_model(input logic signed [31:0] x, input logic m);
    longint a, q, t;
    a = (x < 0) ? -longint'(x) : longint'(x);
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    q = (a * 1024) / (a + 1024);
    t = (x < 0) ? -q : q;
    return m ? int'(t) : int'((1024 + t) / 2);
  endfunction

  task automatic wait_idle();
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic accept(input logic signed [31:0] x, input logic m, input logic [3:0] tg);
    wait_idle();
    @(negedge clk);
    in_data = x; in_mode = m; in_tag = tg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'sh5A5A1234;
    in_mode  = ~m;
    in_tag   = ~tg;
  endtask

  task automatic send_and_check(input logic signed [31:0] x, input logic m,
                                input logic [3:0] tg, input int exp);
    int k = 0;
    out_ready = 1'b1;
    accept(x, m, tg);
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, 12);
    check("data", out_data, exp);
    check("tag", out_tag, tg);
    @(posedge clk); #1;
    check("consumed", out_valid, 0);
    check("ready_after", in_ready, 1);
  endtask

  initial begin
    logic signed [11:0] hold_d;
    logic [3:0]         hold_t;
    logic signed [31:0] rx;
    logic               rm;
    int                 k;
    int                 seen;
    bit                 done;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_tag", out_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;

    send_and_check(32'sd1024,   1'b0, 4'd3,  768);
    send_and_check(32'sd1024,   1'b1, 4'd4,  512);
    send_and_check(-32'sd1024,  1'b0, 4'd5,  256);
    send_and_check(32'sd3072,   1'b0, 4'd6,  896);
    send_and_check(-32'sd3072,  1'b0, 4'd7,  128);
    send_and_check(-32'sd3072,  1'b1, 4'd8,  -768);
    send_and_check(32'sd0,      1'b0, 4'd9,  512);
    send_and_check(32'sd0,      1'b1, 4'd10, 0);
    send_and_check(32'sh7FFFFFFF, 1'b0, 4'd11, 1023);
    send_and_check(32'sh7FFFFFFF, 1'b1, 4'd12, 1023);
    send_and_check(32'sh80000000, 1'b0, 4'd13, 0);
    send_and_check(32'sh80000000, 1'b1, 4'd14, -1023);

    // Backpressure: result must hold for 20 stalled cycles.
    out_ready = 1'b0;
    accept(32'sd3072, 1'b1, 4'd2);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_latency", k, 12);
    hold_d = out_data;
    hold_t = out_tag;
    check("bp_data", hold_d, 768);
    check("bp_tag", hold_t, 2);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, hold_d);
      check("bp_hold_tag", out_tag, hold_t);
      check("bp_in_ready", in_ready, 0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    check("bp_single_xfer", out_valid, 0);

    // Randomised stream against the reference model, random out_ready.
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 0) rx = $urandom();
      else            rx = $signed($urandom_range(0, 16383)) - 32'sd8192;
      rm = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      accept(rx, rm, 4'(i));
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          check("rand_data", out_data, ref_model(rx, rm));
          check("rand_tag", out_tag, i);
          @(posedge clk); #1;
          done = 1'b1;
        end
      end
      if (!done) check("rand_timeout", 0, 1);
    end

    // Reset mid-division: nothing must be emitted.
    out_ready = 1'b1;
    accept(32'sd1024, 1'b0, 4'd1);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_tag", out_tag, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("post_rst_no_output", seen, 0);
    send_and_check(32'sd1024, 1'b0, 4'd15, 768);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
